// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared address map, MMIO offsets and status bit indices for data_mem_responder
package dmem_pkg;

    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

    // The MMIO window is 4 KiB; anything in it that is not a register below is an unmapped offset.
    localparam int MMIO_OFF_W = 12;

    localparam logic [MMIO_OFF_W-1:0] MTIME_LO = 12'h000;
    localparam logic [MMIO_OFF_W-1:0] MTIME_HI = 12'h004;
    localparam logic [MMIO_OFF_W-1:0] TOHOST   = 12'h008;
    localparam logic [MMIO_OFF_W-1:0] STATUS   = 12'h00C;

    localparam int ST_MISALIGNED = 0;
    localparam int ST_OOB        = 1;
    localparam int ST_DONE       = 2;

endpackage

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - free-running 64-bit mtime with mtime_hi snapshot register
module mmio_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        snap_en,
    output logic [31:0] mtime_lo,
    output logic [31:0] shadow_hi
);

    logic [63:0] mtime_d;
    logic [63:0] mtime_q;
    logic [31:0] shadow_hi_d;
    logic [31:0] shadow_hi_q;

    // Next state: count every cycle (natural wrap at 2^64); a mtime_lo read captures the
    // pre-increment upper half so a following mtime_hi read is consistent with it.
    always_comb begin
        mtime_d     = mtime_q + 64'd1;
        shadow_hi_d = shadow_hi_q;
        if (snap_en) begin
            shadow_hi_d = mtime_q[63:32];
        end
    end

    // Timer and snapshot registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_q     <= '0;
            shadow_hi_q <= '0;
        end else begin
            mtime_q     <= mtime_d;
            shadow_hi_q <= shadow_hi_d;
        end
    end

    assign mtime_lo  = mtime_q[31:0];
    assign shadow_hi = shadow_hi_q;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-cycle data RAM responder; MMIO timer/tohost/status compiled in by DMEM_MMIO_EN
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] address,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          done,
    output logic          err
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DW-1:0]    mem [DEPTH];
    logic             access;
    logic             misaligned;
    logic             ram_hit;
    logic             mmio_hit;
    logic             oob_hit;
    logic             ram_we;
    logic [AW-1:0]    ram_off;
    logic [IDX_W-1:0] word_idx;
    logic             misaligned_d;
    logic             misaligned_q;
    logic             oob_d;
    logic             oob_q;

`ifdef DMEM_MMIO_EN
    logic [MMIO_OFF_W-1:0] mmio_off;
    logic                  mmio_rd;
    logic                  mmio_wr;
    logic                  snap_en;
    logic [31:0]           mtime_lo;
    logic [31:0]           shadow_hi;
    logic [31:0]           status_word;
    logic [31:0]           tohost_d;
    logic [31:0]           tohost_q;
    logic                  done_d;
    logic                  done_q;
`endif

    // Address decode: RAM window, MMIO window (when built in), alignment and OOB classification.
    always_comb begin
        ram_off    = address - AW'(RAM_BASE);
        ram_hit    = (ram_off >> (IDX_W + 2)) == '0;
        word_idx   = ram_off[IDX_W+1:2];
        access     = MemRead | MemWrite;
        misaligned = access && (address[1:0] != 2'b00);
`ifdef DMEM_MMIO_EN
        mmio_hit   = (address >> MMIO_OFF_W) == (AW'(MMIO_BASE) >> MMIO_OFF_W);
`else
        mmio_hit   = 1'b0;
`endif
        oob_hit    = access && !ram_hit && !mmio_hit;
        ram_we     = MemWrite && !misaligned && ram_hit && !reset;
    end

    // RAM store; contents are never reset and writes during reset are dropped via ram_we.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[word_idx] <= wdata;
        end
    end

    // Sticky error bits accumulate any misaligned or out-of-bounds access.
    always_comb begin
        misaligned_d = misaligned_q | misaligned;
        oob_d        = oob_q | oob_hit;
    end

    // Error status registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_q <= 1'b0;
            oob_q        <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
            oob_q        <= oob_d;
        end
    end

    assign err = misaligned_q | oob_q;

`ifdef DMEM_MMIO_EN
    // MMIO register decode: tohost write path, done set, mtime snapshot request, status word.
    always_comb begin
        mmio_off    = address[MMIO_OFF_W-1:0];
        mmio_rd     = MemRead && !misaligned && mmio_hit;
        mmio_wr     = MemWrite && !misaligned && mmio_hit;
        snap_en     = mmio_rd && (mmio_off == MTIME_LO);
        status_word = '0;
        status_word[ST_MISALIGNED] = misaligned_q;
        status_word[ST_OOB]        = oob_q;
        status_word[ST_DONE]       = done_q;
        tohost_d    = tohost_q;
        done_d      = done_q;
        if (mmio_wr && (mmio_off == TOHOST)) begin
            tohost_d = 32'(wdata);
            if (wdata[0]) begin
                done_d = 1'b1;
            end
        end
    end

    // tohost and sticky done registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tohost_q <= '0;
            done_q   <= 1'b0;
        end else begin
            tohost_q <= tohost_d;
            done_q   <= done_d;
        end
    end

    mmio_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .snap_en   (snap_en),
        .mtime_lo  (mtime_lo),
        .shadow_hi (shadow_hi)
    );

    assign done = done_q;
`else
    assign done = 1'b0;
`endif

    // Load data: zero unless an aligned read hits RAM or a mapped MMIO register.
    always_comb begin
        rdata = '0;
        if (MemRead && !misaligned) begin
            if (ram_hit) begin
                rdata = mem[word_idx];
            end
`ifdef DMEM_MMIO_EN
            else if (mmio_hit) begin
                case (mmio_off)
                    MTIME_LO: rdata = DW'(mtime_lo);
                    MTIME_HI: rdata = DW'(shadow_hi);
                    TOHOST:   rdata = DW'(tohost_q);
                    STATUS:   rdata = DW'(status_word);
                    default:  rdata = '0;
                endcase
            end
`endif
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized model-checked bench for data_mem_responder (both DMEM_MMIO_EN builds)
module tb_data_mem_responder;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam logic [31:0] MMIO = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        done;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .wdata    (wdata),
        .rdata    (rdata),
        .done     (done),
        .err      (err)
    );

    // Behavioural model state
    logic [31:0]     m_mem [DEPTH];
    bit              m_known [DEPTH];
    longint unsigned m_mtime = 0;
    logic [31:0]     m_shadow = '0;
    logic [31:0]     m_tohost = '0;
    bit              m_done = 1'b0;
    bit              m_mis = 1'b0;
    bit              m_oob = 1'b0;
    bit              chk_en = 1'b1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit in_ram(input logic [31:0] a);
        return a < 32'(DEPTH * 4);
    endfunction

    function automatic bit in_mmio(input logic [31:0] a);
`ifdef DMEM_MMIO_EN
        return (a >= MMIO) && (a < MMIO + 32'h1000);
`else
        return (a != a);
`endif
    endfunction

    task automatic model_reset();
        m_mtime  = 0;
        m_shadow = '0;
        m_tohost = '0;
        m_done   = 1'b0;
        m_mis    = 1'b0;
        m_oob    = 1'b0;
    endtask

    // Compare then advance the model by one clock, using the inputs held for this cycle.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (chk_en) begin
                logic [31:0] e;
                bit          ok;
                bit          acc;
                bit          mis;
                bit          ram;
                bit          mm;
                logic [31:0] off;
                int          idx;
                acc = MemRead || MemWrite;
                mis = acc && (address[1:0] != 2'b00);
                ram = in_ram(address);
                mm  = in_mmio(address);
                off = address - MMIO;
                idx = int'(address >> 2);
                e   = '0;
                ok  = 1'b1;
                if (MemRead && !mis) begin
                    if (ram) begin
                        ok = m_known[idx];
                        e  = m_mem[idx];
                    end else if (mm) begin
                        if (off == 0)       e = 32'(m_mtime);
                        else if (off == 4)  e = m_shadow;
                        else if (off == 8)  e = m_tohost;
                        else if (off == 12) e = {29'd0, m_done, m_oob, m_mis};
                    end
                end
                if (ok) check("rdata", rdata, e);
                check("done", {31'd0, done}, {31'd0, m_done});
                check("err", {31'd0, err}, {31'd0, (m_mis | m_oob)});
                if (reset) begin
                    model_reset();
                end else begin
                    if (mis) m_mis = 1'b1;
                    if (acc && !ram && !mm) m_oob = 1'b1;
                    if (MemWrite && !mis && ram) begin
                        m_mem[idx]   = wdata;
                        m_known[idx] = 1'b1;
                    end
                    if (MemWrite && !mis && mm && off == 8) begin
                        m_tohost = wdata;
                        if (wdata[0]) m_done = 1'b1;
                    end
                    if (MemRead && !mis && mm && off == 0) m_shadow = 32'(m_mtime >> 32);
                    m_mtime = m_mtime + 1;
                end
            end else if (reset) begin
                model_reset();
            end
        end
    end

    task automatic step(input bit rst, input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] wd);
        @(posedge clk);
        #1;
        reset    = rst;
        address  = a;
        MemRead  = rd;
        MemWrite = wr;
        wdata    = wd;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          r;
        logic [31:0] a;
        bit          rd;
        bit          wr;
        bit          rst;

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        step(0, 32'h10, 0, 0, 0);
        check("idle_rdata", rdata, 32'd0);

        // Store then load word 4
        step(0, 32'h10, 0, 1, 32'hDEAD_BEEF);
        step(0, 32'h10, 1, 0, 0);
        check("load_after_store", rdata, 32'hDEAD_BEEF);
        check("err_clean", {31'd0, err}, 32'd0);

        // Read and write together: old data visible, new data next cycle
        step(0, 32'h10, 1, 1, 32'h1234_5678);
        check("rw_same_cycle", rdata, 32'hDEAD_BEEF);
        step(0, 32'h10, 1, 0, 0);
        check("rw_committed", rdata, 32'h1234_5678);

        // Misaligned store is suppressed and flags misaligned
        step(0, 32'h12, 0, 1, 32'hFFFF_FFFF);
        check("err_before_edge", {31'd0, err}, 32'd0);
        step(0, 32'h10, 1, 0, 0);
        check("misaligned_no_write", rdata, 32'h1234_5678);
        check("misaligned_err", {31'd0, err}, 32'd1);
`ifdef DMEM_MMIO_EN
        step(0, MMIO + 32'hC, 1, 0, 0);
        check("status_misaligned", rdata, 32'h1);
`endif

        // OOB load
        step(1, 0, 0, 0, 0);
        step(0, 32'h4000_0000, 1, 0, 0);
        check("oob_rdata", rdata, 32'd0);
        check("err_before_oob_edge", {31'd0, err}, 32'd0);
        step(0, 32'h10, 1, 0, 0);
        check("err_after_oob", {31'd0, err}, 32'd1);
`ifdef DMEM_MMIO_EN
        step(0, MMIO + 32'hC, 1, 0, 0);
        check("status_oob", rdata, 32'h2);

        // mtime starts at 0 after reset and counts
        step(1, 0, 0, 0, 0);
        step(0, MMIO, 1, 0, 0);
        check("mtime_first", rdata, 32'd0);
        step(0, MMIO, 1, 0, 0);
        check("mtime_second", rdata, 32'd1);

        // tohost / done, then reset clears them
        step(0, MMIO + 32'h8, 0, 1, 32'h1);
        check("done_before_edge", {31'd0, done}, 32'd0);
        step(0, MMIO + 32'h8, 1, 0, 0);
        check("done_set", {31'd0, done}, 32'd1);
        check("tohost_read", rdata, 32'h1);
        step(1, 0, 0, 0, 0);
        step(0, MMIO + 32'h8, 1, 0, 0);
        check("tohost_cleared", rdata, 32'd0);
        check("done_cleared", {31'd0, done}, 32'd0);

        // Snapshot across the 32-bit carry
        @(posedge clk);
        #1;
        chk_en   = 1'b0;
        reset    = 1'b0;
        address  = MMIO;
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        force dut.u_timer.mtime_q = 64'h0000_0000_FFFF_FFFF;
        @(negedge clk);
        check("mtime_lo_forced", rdata, 32'hFFFF_FFFF);
        release dut.u_timer.mtime_q;
        step(0, MMIO + 32'h4, 1, 0, 0);
        check("mtime_hi_snapshot", rdata, 32'd0);
        step(1, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        reset  = 1'b0;
        MemRead = 1'b0;
        @(negedge clk);
`else
        // MMIO region decodes as OOB when not built in
        step(1, 0, 0, 0, 0);
        step(0, MMIO, 1, 0, 0);
        check("nommio_rdata", rdata, 32'd0);
        step(0, MMIO + 32'h8, 0, 1, 32'h1);
        check("nommio_oob", {31'd0, err}, 32'd1);
        step(0, 0, 0, 0, 0);
        check("nommio_done", {31'd0, done}, 32'd0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 50) begin
                a = 32'($urandom_range(0, DEPTH - 1)) * 4;
            end else if (r < 58) begin
                a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
            end else if (r < 70) begin
                case ($urandom_range(0, 3))
                    0:       a = 32'(DEPTH * 4) + 32'($urandom_range(0, 255)) * 4;
                    1:       a = 32'h4000_0000;
                    2:       a = MMIO + 32'h1000 + 32'($urandom_range(0, 15)) * 4;
                    default: a = 32'hFFFF_FFFC;
                endcase
            end else begin
                case ($urandom_range(0, 6))
                    0:       a = MMIO;
                    1:       a = MMIO + 32'h4;
                    2:       a = MMIO + 32'h8;
                    3:       a = MMIO + 32'hC;
                    4:       a = MMIO + 32'h10;
                    5:       a = MMIO + 32'hFFC;
                    default: a = MMIO + 32'($urandom_range(1, 3));
                endcase
            end
            rd  = ($urandom_range(0, 99) < 70);
            wr  = ($urandom_range(0, 99) < 40);
            rst = ($urandom_range(0, 99) < 2);
            step(rst, a, rd, wr, $urandom);
        end

        step(0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits; only 32 is supported.
REQ-003 Parameter DEPTH, default 1024, number of 32-bit RAM words; power of two.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 address  input  AW  byte address from the core.
REQ-007 MemRead  input  1  load request, valid for the current cycle.
REQ-008 MemWrite  input  1  store request, committed at the next posedge.
REQ-009 wdata  input  DW  store data.
REQ-010 rdata  output  DW  load data, combinational within the same cycle.
REQ-011 done  output  1  sticky test-complete flag.
REQ-012 err  output  1  OR of the sticky error bits.

Function
REQ-013 Address map: RAM spans 0x0000_0000 to DEPTH*4-1; MMIO base is 0x8000_0000; every other address is out-of-bounds (OOB).
REQ-014 RAM load: rdata = mem[address[log2(DEPTH)+1:2]], combinational, zero wait states.
REQ-015 RAM store: at the posedge with MemWrite=1, mem[word] <= wdata; full word only.
REQ-016 With MemRead and MemWrite both 1, rdata shows the pre-write contents and the write commits at the edge.
REQ-017 With MemRead=0, rdata SHALL be 0.
REQ-018 A misaligned access (address[1:0]!=0 with MemRead or MemWrite) suppresses the write, drives rdata=0, and sets status.misaligned at the next edge.
REQ-019 An OOB access suppresses the write, drives rdata=0, and sets status.oob at the next edge.
REQ-020 err = status.misaligned | status.oob, registered; the bits clear only on reset.
REQ-021 MMIO offset 0x00 is mtime_lo (RO); a read of it latches mtime[63:32] into shadow_hi at that edge.
REQ-022 MMIO offset 0x04 is mtime_hi (RO); a read of it returns shadow_hi, not live mtime.
REQ-023 MMIO offset 0x08 is tohost (RW); a write stores wdata, and wdata[0]=1 sets done (sticky).
REQ-024 MMIO offset 0x0C is status (RO): bit0 = misaligned, bit1 = oob, bit2 = done, other bits 0.
REQ-025 Writes to RO MMIO registers and to unmapped MMIO offsets are ignored without error; reads of unmapped offsets return 0.
REQ-026 mtime is 64 bits, increments by 1 every cycle after reset, and wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-027 When the mtime_lo read and the increment fall on the same edge, shadow_hi captures the pre-increment mtime[63:32].

Reset
REQ-028 While reset=1: mtime=0, shadow_hi=0, tohost=0, done=0, status=0, err=0.
REQ-029 RAM contents are not reset; stores issued during reset are ignored.
REQ-030 Reset asserted mid-run clears all MMIO state at that edge; mtime reads 0 in the first cycle after reset deasserts.

Configuration
REQ-031 Macro DMEM_MMIO_EN, when defined, compiles in the MMIO region, mtime, tohost and the done logic.
REQ-032 Without DMEM_MMIO_EN, the MMIO region decodes as OOB, done is tied to 0, and no timer logic is synthesized.

Structure
REQ-033 Shared package dmem_pkg holds RAM_BASE, MMIO_BASE, the MMIO offset constants (MTIME_LO, MTIME_HI, TOHOST, STATUS) and the status bit indices.
REQ-034 One sub-module, mmio_timer, holds mtime, shadow_hi and the snapshot logic; the RAM and decode stay in the top module.

Verification
REQ-035 Store 0xDEADBEEF to 0x0000_0010, then load from 0x0000_0010 -> rdata = 0xDEADBEEF; err = 0.
REQ-036 Store to 0x0000_0012 -> RAM unchanged at word 4, status = 0x1, err = 1 from the next cycle.
REQ-037 Load from 0x4000_0000 -> rdata = 0, status.oob = 1; a later valid access leaves err = 1.
REQ-038 Force mtime to 0x0000_0000_FFFF_FFFF, read mtime_lo, then read mtime_hi on the next cycle -> 0xFFFF_FFFF, then 0x0000_0000 (snapshot, not 1).
REQ-039 Write 0x1 to 0x8000_0008 -> done = 1 next cycle; reset pulse -> done = 0 and tohost = 0.
REQ-040 Build without DMEM_MMIO_EN and read 0x8000_0000 -> rdata = 0, status.oob = 1, done stays 0.
